// File: rtl/conv_mac_accum_param_2_pkg.sv
// Shared widths and tap classification for the param_2 convolution MAC.
// The ReLU stage imports the same defaults so both stages agree on widths.
package conv_mac_accum_param_2_pkg;

    localparam int DEF_DATA_WIDTH           = 16;
    localparam int DEF_ACCUM_DATA_WIDTH     = 44;
    localparam int DEF_COUNT_SLOAD_BITWIDTH = 5;
    localparam int DEF_KERNEL_TAPS          = 25;

    typedef enum logic {
        TAP_SLOAD = 1'b0,
        TAP_ACCUM = 1'b1
    } tap_kind_e;

endpackage

// File: rtl/conv_mac_accum_param_2_if.sv
// Operand stream in, completed window sum and tap counter out.
interface conv_mac_accum_param_2_if
    import conv_mac_accum_param_2_pkg::*;
#(
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
    parameter int COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH
);

    logic                                enable;
    logic signed [DATA_WIDTH-1:0]        data_in;
    logic signed [DATA_WIDTH-1:0]        weight_in;
    logic signed [ACCUM_DATA_WIDTH-1:0]  result;
    logic [COUNT_SLOAD_BITWIDTH-1:0]     count_sload;
    logic                                result_valid;

    modport master (
        output enable, data_in, weight_in,
        input  result, count_sload, result_valid
    );

    modport slave (
        input  enable, data_in, weight_in,
        output result, count_sload, result_valid
    );

endinterface

// File: rtl/signed_mult_reg_param_2.sv
// Stage-1 registered signed multiplier; the product holds while enable is low.
module signed_mult_reg_param_2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic signed [DATA_WIDTH-1:0]   data_in,
    input  logic signed [DATA_WIDTH-1:0]   weight_in,
    output logic signed [2*DATA_WIDTH-1:0] prod,
    output logic                           vld
);

    // stage 0 -> stage 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod <= '0;
            vld  <= 1'b0;
        end else begin
            vld <= enable;
            if (enable) begin
                prod <= (2*DATA_WIDTH)'(data_in) * (2*DATA_WIDTH)'(weight_in);
            end
        end
    end

endmodule

// File: rtl/conv_mac_accum_param_2.sv
// Pixel*weight MAC: accumulates KERNEL_TAPS products per window and publishes
// the completed sum, held stable for the whole following window.
module conv_mac_accum_param_2
    import conv_mac_accum_param_2_pkg::*;
#(
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
    parameter int COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH,
    parameter int KERNEL_TAPS          = DEF_KERNEL_TAPS
) (
    input  logic                    clock,
    input  logic                    reset,
    conv_mac_accum_param_2_if.slave bus
);

    localparam logic [COUNT_SLOAD_BITWIDTH-1:0] LAST_TAP =
        COUNT_SLOAD_BITWIDTH'(KERNEL_TAPS - 1);

    function automatic logic signed [ACCUM_DATA_WIDTH-1:0] sign_extend(
        input logic signed [2*DATA_WIDTH-1:0] value
    );
        return ACCUM_DATA_WIDTH'(value);
    endfunction

    logic signed [2*DATA_WIDTH-1:0]     prod_p1;
    logic                               vld_p1;
    logic signed [ACCUM_DATA_WIDTH-1:0] prod_ext_p1;
    logic signed [ACCUM_DATA_WIDTH-1:0] sum_p1;
    logic signed [ACCUM_DATA_WIDTH-1:0] acc_p2;
    logic signed [ACCUM_DATA_WIDTH-1:0] result_p2;
    logic [COUNT_SLOAD_BITWIDTH-1:0]    count_p2;
    logic                               vld_p2;
    tap_kind_e                          kind_p1;

    signed_mult_reg_param_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clock     (clock),
        .reset     (reset),
        .enable    (bus.enable),
        .data_in   (bus.data_in),
        .weight_in (bus.weight_in),
        .prod      (prod_p1),
        .vld       (vld_p1)
    );

    // stage 1 -> stage 2: sload restarts the sum, other taps add (wrapping)
    always_comb begin
        prod_ext_p1 = sign_extend(prod_p1);
        kind_p1     = (count_p2 == '0) ? TAP_SLOAD : TAP_ACCUM;
        sum_p1      = (kind_p1 == TAP_SLOAD) ? prod_ext_p1 : acc_p2 + prod_ext_p1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_p2    <= '0;
            result_p2 <= '0;
            count_p2  <= '0;
            vld_p2    <= 1'b0;
        end else if (vld_p1) begin
            acc_p2 <= sum_p1;
            if (count_p2 == LAST_TAP) begin
                result_p2 <= sum_p1;
                vld_p2    <= 1'b1;
                count_p2  <= '0;
            end else begin
                vld_p2   <= 1'b0;
                count_p2 <= count_p2 + 1'b1;
            end
        end else begin
            vld_p2 <= 1'b0;
        end
    end

    assign bus.result       = result_p2;
    assign bus.count_sload  = count_p2;
    assign bus.result_valid = vld_p2;

endmodule

// File: tb/tb_conv_mac_accum_param_2.sv
// Bench for conv_mac_accum_param_2: directed windows plus random stream,
// compared every cycle against a tap-counting window-sum model.
module tb_conv_mac_accum_param_2;

    localparam int K = 25;

    logic clock;
    logic reset;

    int checks   = 0;
    int failures = 0;

    conv_mac_accum_param_2_if bus ();

    conv_mac_accum_param_2 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model: expected outputs after the most recent rising edge
    logic signed [43:0] exp_result;
    logic               exp_valid;
    int                 exp_count;
    logic signed [43:0] wsum;
    int                 landed;
    logic               pend_v;
    logic signed [43:0] pend_p;

    bit                 chk_on = 1'b0;
    int                 cyc    = 0;
    int                 pulses[$];
    logic signed [43:0] res_at2;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        exp_result = '0;
        exp_valid  = 1'b0;
        exp_count  = 0;
        wsum       = '0;
        landed     = 0;
        pend_v     = 1'b0;
        pend_p     = '0;
    endtask

    // one cycle: drive operands, advance model to the next rising edge
    task automatic step(input logic en, input logic signed [15:0] d,
                        input logic signed [15:0] w);
        @(negedge clock);
        #1;
        bus.enable    = en;
        bus.data_in   = d;
        bus.weight_in = w;
        if (!reset) begin
            model_clear();
        end else begin
            exp_valid = 1'b0;
            if (pend_v) begin
                wsum   = (landed == 0) ? pend_p : wsum + pend_p;
                landed = landed + 1;
                if (landed == K) begin
                    exp_result = wsum;
                    exp_valid  = 1'b1;
                    landed     = 0;
                end
            end
            exp_count = landed;
            pend_v    = en;
            pend_p    = d * w;
        end
    endtask

    task automatic window(input logic signed [15:0] d, input logic signed [15:0] w);
        for (int i = 0; i < K; i++) step(1'b1, d, w);
    endtask

    // after the last tap: two idle cycles, then result is visible with its pulse
    task automatic settle_and_pin(input string name, input logic signed [63:0] lit);
        step(1'b0, 16'sd0, 16'sd0);
        step(1'b0, 16'sd0, 16'sd0);
        check({name, "_model"}, exp_result, lit);
        check(name, $signed(bus.result), lit);
        check({name, "_pulse"}, {63'd0, bus.result_valid}, 64'd1);
        step(1'b0, 16'sd0, 16'sd0);
        check({name, "_pulse_end"}, {63'd0, bus.result_valid}, 64'd0);
        check({name, "_count0"}, {59'd0, bus.count_sload}, 64'd0);
    endtask

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                cyc++;
                check("result", $signed(bus.result), exp_result);
                check("result_valid", {63'd0, bus.result_valid}, {63'd0, exp_valid});
                check("count_sload", {59'd0, bus.count_sload}, 64'(exp_count));
                if (bus.result_valid) pulses.push_back(cyc);
                if (bus.count_sload == 5'd2) res_at2 = bus.result;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] big;
        logic signed [15:0] rd;
        logic signed [15:0] rw;
        int gaps_ok;

        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.data_in   = '0;
        bus.weight_in = '0;
        model_clear();
        #1 reset = 1'b0;
        #2 chk_on = 1'b1;
        check("reset_result", $signed(bus.result), 64'sd0);
        check("reset_count", {59'd0, bus.count_sload}, 64'd0);
        check("reset_valid", {63'd0, bus.result_valid}, 64'd0);
        step(1'b0, 16'sd0, 16'sd0);
        step(1'b0, 16'sd0, 16'sd0);
        @(negedge clock);
        #2 reset = 1'b1;

        window(16'sd1, 16'sd1);
        settle_and_pin("ones", 64'sd25);

        window(-16'sd2, 16'sd3);
        settle_and_pin("neg", -64'sd150);
        check("neg_sext_bits", {20'd0, bus.result}, {20'd0, 44'hFFFFFFFFF6A});

        big = 16'sh8000;
        window(big, big);
        settle_and_pin("maxneg", 64'sh640000000);

        // ramp with gaps after taps 5 and 17, then an all-2 window
        for (int k = 1; k <= K; k++) begin
            step(1'b1, 16'(k), 16'sd1);
            if (k == 5 || k == 17) begin
                for (int g = 0; g < 3; g++) step(1'b0, 16'sd0, 16'sd0);
            end
        end
        settle_and_pin("ramp", 64'sd325);
        res_at2 = '0;
        window(16'sd2, 16'sd1);
        check("hold_at_count2", res_at2, 64'sd325);
        settle_and_pin("twos", 64'sd50);

        // async reset mid-window discards the partial sum
        for (int i = 0; i < 10; i++) step(1'b1, 16'sd7, 16'sd1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check("async_result", $signed(bus.result), 64'sd0);
        check("async_count", {59'd0, bus.count_sload}, 64'd0);
        check("async_valid", {63'd0, bus.result_valid}, 64'd0);
        step(1'b0, 16'sd0, 16'sd0);
        @(negedge clock);
        #2 reset = 1'b1;
        window(16'sd1, 16'sd1);
        settle_and_pin("after_reset", 64'sd25);

        // three back-to-back windows
        pulses.delete();
        for (int i = 0; i < 3 * K; i++) step(1'b1, 16'sd1, 16'sd2);
        step(1'b0, 16'sd0, 16'sd0);
        step(1'b0, 16'sd0, 16'sd0);
        step(1'b0, 16'sd0, 16'sd0);
        check("b2b_pulse_count", 64'(pulses.size()), 64'sd3);
        gaps_ok = 1;
        for (int i = 1; i < pulses.size(); i++) begin
            if (pulses[i] - pulses[i-1] != K) gaps_ok = 0;
        end
        check("b2b_pulse_spacing", 64'(gaps_ok), 64'sd1);
        check("b2b_result", $signed(bus.result), 64'sd50);

        // random stream with random gaps
        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom);
            rw = 16'($urandom);
            step(($urandom_range(0, 3) != 0), rd, rw);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'sd0, 16'sd0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
